// File: rtl/layer3_pkg.sv
// layer3_pkg: shared sizes, widths and FSM states for the layer-3 feeder
package layer3_pkg;
  localparam int N_IN  = 256;
  localparam int N_OUT = 120;
  localparam int ACT_W = 18;
  localparam int WGT_W = 16;
  localparam int OUT_W = 16;
  localparam int I_W   = $clog2(N_IN);
  localparam int N_W   = $clog2(N_OUT);
  localparam int WA_W  = $clog2(N_IN * N_OUT);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT1, WAIT2} state_t;
endpackage

// File: rtl/layer3_feeder_if.sv
// layer3_feeder_if: memory read ports and PE ena/finish bus of the layer-3 feeder
interface layer3_feeder_if;
  import layer3_pkg::*;
  logic [I_W-1:0]            act_addr;
  logic [WA_W-1:0]           w_addr;
  logic [N_W-1:0]            bias_addr;
  logic signed [ACT_W-1:0]   act_rdata, pe_din1;
  logic signed [WGT_W-1:0]   w_rdata, bias_rdata, pe_din2, pe_bias;
  logic signed [OUT_W-1:0]   pe_dout;
  logic                      pe_reset, pe_ena, pe_finish;
  modport master (
    output act_addr, w_addr, bias_addr, pe_reset, pe_ena, pe_din1, pe_din2, pe_bias,
    input  act_rdata, w_rdata, bias_rdata, pe_dout, pe_finish
  );
  modport slave (
    input  act_addr, w_addr, bias_addr, pe_reset, pe_ena, pe_din1, pe_din2, pe_bias,
    output act_rdata, w_rdata, bias_rdata, pe_dout, pe_finish
  );
endinterface

// File: rtl/layer3_addr_gen.sv
// layer3_addr_gen: neuron/input counters, weight address and delayed issue flag (pe_ena)
module layer3_addr_gen
  import layer3_pkg::*;
#(
  parameter int N_NEURON = N_OUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            idle,
  input  logic            stream,
  input  logic            adv,
  output logic [I_W-1:0]  i,
  output logic [N_W-1:0]  neuron,
  output logic [WA_W-1:0] w_addr,
  output logic            ena,
  output logic            last_i,
  output logic            last_n
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      i      <= '0;
      neuron <= '0;
      ena    <= 1'b0;
    end else begin
      i      <= stream ? i + 1'b1 : '0;
      neuron <= idle ? '0 : adv ? neuron + 1'b1 : neuron;
      ena    <= stream;
    end
  end
  assign w_addr = WA_W'(neuron) * WA_W'(N_IN) + WA_W'(i);
  assign last_i = i == I_W'(N_IN - 1);
  assign last_n = neuron == N_W'(N_NEURON - 1);
endmodule

// File: rtl/layer3_feeder.sv
// layer3_feeder: sequences per-neuron activation/weight streaming into the layer-3 PE
module layer3_feeder
  import layer3_pkg::*;
#(
  parameter int N_NEURON = N_OUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  output logic [N_W-1:0]          out_idx,
  output logic signed [OUT_W-1:0] out_data,
  layer3_feeder_if.master         bus
);
  state_t         state, state_n;
  logic [I_W-1:0] i;
  logic [N_W-1:0] neuron;
  logic           last_i, last_n, cap;
  // only the first finish cycle carries a valid result; leaving WAIT2 enforces that
  assign cap = state == WAIT2 && bus.pe_finish;
  layer3_addr_gen #(.N_NEURON(N_NEURON)) u_addr (
    .clk    (clk),
    .reset  (reset),
    .idle   (state == IDLE),
    .stream (state == STREAM),
    .adv    (cap && !last_n),
    .i      (i),
    .neuron (neuron),
    .w_addr (bus.w_addr),
    .ena    (bus.pe_ena),
    .last_i (last_i),
    .last_n (last_n)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      out_valid <= cap;
      done      <= cap && last_n;
      if (cap) begin
        out_idx  <= neuron;
        out_data <= bus.pe_dout;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start && !done ? CLEAR : IDLE;
      CLEAR:   state_n = STREAM;
      STREAM:  state_n = last_i ? WAIT1 : STREAM;
      WAIT1:   state_n = WAIT2;
      WAIT2:   state_n = !bus.pe_finish ? WAIT2 : last_n ? IDLE : CLEAR;
      default: state_n = IDLE;
    endcase
  end
  // done keeps busy high so a start in the done cycle is ignored
  assign busy          = state != IDLE || done;
  assign bus.act_addr  = i;
  assign bus.bias_addr = neuron;
  assign bus.pe_reset  = state == IDLE || state == CLEAR;
  assign bus.pe_din1   = bus.act_rdata;
  assign bus.pe_din2   = bus.w_rdata;
  assign bus.pe_bias   = bus.bias_rdata;
endmodule

// File: tb/tb_layer3_feeder.sv
// tb_layer3_feeder: scoreboard bench with behavioural memories and PE, N_NEURON=2
module tb_layer3_feeder;
  import layer3_pkg::*;
  localparam int NN = 2;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, out_valid;
  logic [N_W-1:0] out_idx;
  logic signed [OUT_W-1:0] out_data;
  layer3_feeder_if bus();

  layer3_feeder #(.N_NEURON(NN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // memories with one-cycle read latency
  logic signed [ACT_W-1:0] act_mem [256];
  logic signed [WGT_W-1:0] w_mem [512];
  logic signed [WGT_W-1:0] b_mem [2];
  always @(posedge clk) begin
    bus.act_rdata  <= act_mem[bus.act_addr];
    bus.w_rdata    <= w_mem[bus.w_addr[8:0]];
    bus.bias_rdata <= b_mem[bus.bias_addr[0]];
  end

  // PE model: unit scaling, ReLU, re-adds bias each extra finish cycle
  int acc, cnt, dly, fcnt, pe_sum, fin_delay;
  bit stub;
  always @(posedge clk) begin
    if (bus.pe_reset) begin
      acc <= 0; cnt <= 0; dly <= 0; fcnt <= 0;
    end else begin
      if (bus.pe_ena) begin
        acc <= acc + int'(bus.pe_din1) * int'(bus.pe_din2);
        cnt <= cnt + 1;
      end
      if (cnt == 256) begin
        if (dly < fin_delay) dly <= dly + 1;
        else fcnt <= fcnt + 1;
      end
    end
  end
  always_comb begin
    pe_sum = acc + int'(bus.pe_bias) * (fcnt + 1);
    bus.pe_finish = cnt == 256 && dly >= fin_delay;
    bus.pe_dout = stub ? 16'(16'h0123 + fcnt) :
                  pe_sum < 0 ? 16'sd0 : pe_sum > 32767 ? 16'sh7fff : 16'(pe_sum);
  end

  // scoreboard
  typedef struct {int idx; int data; bit last; int at;} exp_t;
  exp_t q[$];
  exp_t e;
  int run_s;
  bit run_on = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: idx %0d data %0h at cycle %0d, none expected", out_idx, out_data, cyc);
        end else begin
          e = q.pop_front();
          chk("out_idx", 64'(out_idx), 64'(e.idx));
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("done_with_valid", 64'(done), 64'(e.last));
          chk("out_cycle", 64'(cyc), 64'(e.at));
        end
      end else if (done) chk("done_without_valid", 64'(done), 64'd0);
    end
  end

  // per-cycle address/control reference for runs without finish delay
  int k, n, p;
  always @(negedge clk) begin
    if (run_on) begin
      k = cyc - run_s + 1;
      if (k >= 1 && k <= 259 * NN) begin
        n = (k - 1) / 259;
        p = (k - 1) % 259;
        if (p >= 1 && p <= 256)
          chk("stream", {bus.act_addr, bus.w_addr, bus.bias_addr, bus.pe_ena, bus.pe_reset, busy},
              {8'(p - 1), 15'(n * 256 + p - 1), 7'(n), (p >= 2), 1'b0, 1'b1});
        else
          chk("ctrl", {bus.bias_addr, bus.pe_ena, bus.pe_reset, busy},
              {7'(n), (p == 257), (p == 0), 1'b1});
      end
    end
  end

  task automatic load(bit mode, int b0, int b1);
    for (int j = 0; j < 256; j++) act_mem[j] = mode ? 18'(j % 4) : 18'sd1;
    for (int j = 0; j < 512; j++) w_mem[j] = mode ? (j < 256 ? 16'sd1 : 16'sd2) : 16'sd1;
    b_mem[0] = 16'(b0);
    b_mem[1] = 16'(b1);
  endtask

  // called at a negedge; start is sampled at the next posedge
  task automatic start_run(bit chk_addr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_s = cyc;
    run_on = chk_addr;
  endtask

  task automatic push(int idx, int data, int d);
    q.push_back('{idx, data, idx == NN - 1, run_s + 259 + d + idx * (259 + d)});
  endtask

  task automatic wait_done(int budget);
    bit seen = 1'b0;
    for (int j = 0; j < budget && !seen; j++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 64'(seen), 64'd1);
    run_on = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ctrl"}, {busy, done, out_valid, bus.pe_ena, bus.pe_reset}, 5'b00001);
    chk({tag, "_addr"}, {bus.act_addr, bus.w_addr, bus.bias_addr}, '0);
    chk({tag, "_out"}, {out_idx, out_data}, '0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stub = 1'b0; fin_delay = 0;
    load(1'b0, -300, 5);
    repeat (3) @(negedge clk);
    chk_reset("init");
    reset = 1'b1;
    @(negedge clk);
    // unit data: 256-300 -> ReLU 0, 256+5 = 261; stray starts during the run
    start_run(1'b1);
    push(0, 0, 0);
    push(1, 261, 0);
    fork
      begin
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (249) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join_none
    wait_done(700);
    // start in the done cycle is ignored, one cycle later accepted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_ignored", {busy, bus.pe_reset}, 2'b01);
    // act=i%4, w=1|2, bias 10|100, finish arrives 2 cycles late
    load(1'b1, 10, 100);
    fin_delay = 2;
    start_run(1'b0);
    push(0, 394, 2);
    push(1, 868, 2);
    wait_done(700);
    @(negedge clk);
    // stub PE: only first finish value is valid
    stub = 1'b1;
    fin_delay = 0;
    start_run(1'b1);
    push(0, 'h123, 0);
    push(1, 'h123, 0);
    wait_done(700);
    @(negedge clk);
    stub = 1'b0;
    // abort mid-stream at i=100
    load(1'b0, 7, -1);
    start_run(1'b1);
    repeat (102) @(negedge clk);
    reset = 1'b0;
    run_on = 1'b0;
    @(negedge clk);
    chk_reset("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    // fresh run restarts at neuron 0, w_addr 0: 263 and 255
    start_run(1'b1);
    push(0, 263, 0);
    push(1, 255, 0);
    wait_done(700);
    @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
